vectored_int_ctrl: RTL and testbench



---
 rtl/vectored_int_ctrl_if.sv | 28 ++
 rtl/vectored_int_ctrl.sv | 146 ++++++++++++++
 tb/tb_vectored_int_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vectored_int_ctrl_if.sv
// Bundle of peripheral, mask and core-handshake signals around the vectored
// interrupt controller. The controller uses the master side: it owns the
// request, the vector and the status outputs. The environment (peripherals
// plus core) uses the slave side.
interface vectored_int_ctrl_if;
  logic        done1;
  logic        done2;
  logic        done3;
  logic        done4;
  logic [3:0]  int_mask;
  logic        int_ack;
  logic        eoi;
  logic        interrupt;
  logic [31:0] int_addr;
  logic [1:0]  int_id;
  logic        in_service;
  logic [3:0]  pending;

  modport master (
    input  done1, done2, done3, done4, int_mask, int_ack, eoi,
    output interrupt, int_addr, int_id, in_service, pending
  );

  modport slave (
    output done1, done2, done3, done4, int_mask, int_ack, eoi,
    input  interrupt, int_addr, int_id, in_service, pending
  );
endinterface

// File: rtl/vectored_int_ctrl.sv
// Four-source vectored interrupt controller for the single-cycle MIPS core.
// Completion edges from the peripherals are latched as pending bits. The
// lowest-numbered eligible source wins and is presented as a single request
// together with its handler vector. The controller then walks the
// ack / end-of-interrupt handshake, so only one handler is ever in service.
module vectored_int_ctrl #(
  parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
  parameter int unsigned VEC_SHIFT = 4
) (
  input logic              clk,
  input logic              reset_n,
  vectored_int_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Handler vector for a source index; 32-bit arithmetic that wraps on overflow.
  function automatic logic [31:0] vec_addr(input logic [1:0] id);
    vec_addr = VEC_BASE + ({30'd0, id} << VEC_SHIFT);
  endfunction

  state_t      state;
  state_t      state_next;
  logic [3:0]  done_now;
  logic [3:0]  done_q;
  logic [3:0]  rise;
  logic [3:0]  clr;
  logic [3:0]  eligible;
  logic [3:0]  pending_reg;
  logic [3:0]  pending_next;
  logic [1:0]  winner;
  logic        irq_reg;
  logic        irq_next;
  logic [1:0]  id_reg;
  logic [1:0]  id_next;
  logic [31:0] addr_reg;
  logic [31:0] addr_next;
  logic        svc_reg;
  logic        svc_next;

  assign done_now = {bus.done4, bus.done3, bus.done2, bus.done1};
  assign rise     = done_now & ~done_q;
  assign eligible = pending_reg & bus.int_mask;

  // Fixed priority: the lowest set index wins.
  always_comb begin
    winner = 2'd0;
    if (eligible[0]) begin
      winner = 2'd0;
    end else if (eligible[1]) begin
      winner = 2'd1;
    end else if (eligible[2]) begin
      winner = 2'd2;
    end else begin
      winner = 2'd3;
    end
  end

  // The acknowledged source is cleared. A new rise in the same cycle still sets the bit, so it re-pends.
  always_comb begin
    clr = 4'b0000;
    if ((state == REQ) && bus.int_ack) begin
      clr = 4'b0001 << id_reg;
    end else begin
      clr = 4'b0000;
    end
    pending_next = (pending_reg & ~clr) | rise;
  end

  // Next-state and next-output logic for the request/service handshake.
  always_comb begin
    state_next = state;
    irq_next   = irq_reg;
    id_next    = id_reg;
    addr_next  = addr_reg;
    svc_next   = svc_reg;
    case (state)
      IDLE: begin
        if (eligible != 4'b0000) begin
          state_next = REQ;
          irq_next   = 1'b1;
          id_next    = winner;
          addr_next  = vec_addr(winner);
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        // The request is held as issued: no preemption, no retraction on mask changes.
        if (bus.int_ack) begin
          state_next = SERVICE;
          irq_next   = 1'b0;
          svc_next   = 1'b1;
        end else begin
          state_next = REQ;
        end
      end
      SERVICE: begin
        // int_id/int_addr keep the last served source after the handler returns.
        if (bus.eoi) begin
          state_next = IDLE;
          svc_next   = 1'b0;
        end else begin
          state_next = SERVICE;
        end
      end
      default: begin
        state_next = IDLE;
        irq_next   = 1'b0;
        svc_next   = 1'b0;
      end
    endcase
  end

  // Register all state and outputs; async reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      done_q      <= 4'b0000;
      pending_reg <= 4'b0000;
      irq_reg     <= 1'b0;
      id_reg      <= 2'd0;
      addr_reg    <= 32'd0;
      svc_reg     <= 1'b0;
    end else begin
      state       <= state_next;
      done_q      <= done_now;
      pending_reg <= pending_next;
      irq_reg     <= irq_next;
      id_reg      <= id_next;
      addr_reg    <= addr_next;
      svc_reg     <= svc_next;
    end
  end

  assign bus.interrupt  = irq_reg;
  assign bus.int_id     = id_reg;
  assign bus.int_addr   = addr_reg;
  assign bus.in_service = svc_reg;
  assign bus.pending    = pending_reg;

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Self-checking bench for vectored_int_ctrl. Expected vectors are queued when
// a request is stimulated and popped when the controller raises interrupt.
module tb_vectored_int_ctrl;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  logic [31:0] exp_addr_q[$];
  logic [1:0]  exp_id_q[$];
  logic [31:0] exp_addr;
  logic [1:0]  exp_id;

  vectored_int_ctrl_if bus();

  vectored_int_ctrl #(
    .VEC_BASE (32'h0000_0100),
    .VEC_SHIFT(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_done(input logic [3:0] v);
    bus.done1 = v[0];
    bus.done2 = v[1];
    bus.done3 = v[2];
    bus.done4 = v[3];
  endtask

  task automatic push_exp(input logic [1:0] id);
    exp_id_q.push_back(id);
    exp_addr_q.push_back(32'h0000_0100 + 32'(id) * 32'd16);
  endtask

  task automatic pop_exp();
    if (exp_id_q.size() == 0) begin
      exp_id   = 2'd0;
      exp_addr = 32'hDEAD_BEEF;
    end else begin
      exp_id   = exp_id_q.pop_front();
      exp_addr = exp_addr_q.pop_front();
    end
  endtask

  // Waits (bounded) for interrupt to be high; reports whether it was seen and after how many edges.
  task automatic wait_interrupt(input int max, output bit seen, output int n);
    n = 0;
    while ((n < max) && (bus.interrupt !== 1'b1)) begin
      tick();
      n++;
    end
    seen = (bus.interrupt === 1'b1);
  endtask

  // Acknowledge the current request, then end its handler; leaves the FSM in IDLE.
  task automatic service_current();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.interrupt !== 1'b0 || bus.pending !== 4'b0000 || bus.in_service !== 1'b0 ||
        bus.int_addr !== 32'd0 || bus.int_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_initial: int=%b pend=%b svc=%b addr=%h id=%0d, want all 0",
               bus.interrupt, bus.pending, bus.in_service, bus.int_addr, bus.int_id);
    end
    reset_n = 1'b1;
    tick();
    set_done(4'b0001);
    tick();
    set_done(4'b0000);
    tick();
    checks++;
    if (bus.interrupt !== 1'b1 || bus.int_addr !== 32'h100) begin
      errors++;
      $display("FAIL reset_prereq: int=%b addr=%h, want 1/00000100", bus.interrupt, bus.int_addr);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.interrupt !== 1'b0 || bus.pending !== 4'b0000 || bus.in_service !== 1'b0 ||
        bus.int_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: int=%b pend=%b svc=%b addr=%h, want all 0",
               bus.interrupt, bus.pending, bus.in_service, bus.int_addr);
    end
    #1;
    reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.interrupt !== 1'b0 || bus.pending !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: int=%b pend=%b, want 0/0000", bus.interrupt, bus.pending);
    end
  endtask

  task automatic test_single();
    push_exp(2'd2);
    set_done(4'b0100);
    tick();
    set_done(4'b0000);
    checks++;
    if (bus.pending !== 4'b0100 || bus.interrupt !== 1'b0) begin
      errors++;
      $display("FAIL single_pending: pend=%b int=%b, want 0100/0", bus.pending, bus.interrupt);
    end
    tick();
    pop_exp();
    checks++;
    if (bus.interrupt !== 1'b1 || bus.int_addr !== exp_addr || bus.int_id !== exp_id) begin
      errors++;
      $display("FAIL single_req: int=%b addr=%h id=%0d, want 1 %h %0d",
               bus.interrupt, bus.int_addr, bus.int_id, exp_addr, exp_id);
    end
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    checks++;
    if (bus.interrupt !== 1'b0 || bus.pending !== 4'b0000 || bus.in_service !== 1'b1) begin
      errors++;
      $display("FAIL single_ack: int=%b pend=%b svc=%b, want 0 0000 1",
               bus.interrupt, bus.pending, bus.in_service);
    end
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    checks++;
    if (bus.in_service !== 1'b0 || bus.int_id !== 2'd2 || bus.int_addr !== 32'h120) begin
      errors++;
      $display("FAIL single_eoi: svc=%b id=%0d addr=%h, want 0 2 00000120",
               bus.in_service, bus.int_id, bus.int_addr);
    end
    tick();
  endtask

  task automatic test_priority();
    push_exp(2'd1);
    push_exp(2'd3);
    set_done(4'b1010);
    tick();
    set_done(4'b0000);
    tick();
    pop_exp();
    checks++;
    if (bus.interrupt !== 1'b1 || bus.int_addr !== exp_addr || bus.int_id !== exp_id) begin
      errors++;
      $display("FAIL prio_first: int=%b addr=%h id=%0d, want 1 %h %0d",
               bus.interrupt, bus.int_addr, bus.int_id, exp_addr, exp_id);
    end
    service_current();
    checks++;
    if (bus.interrupt !== 1'b0 || bus.pending !== 4'b1000) begin
      errors++;
      $display("FAIL prio_idle_gap: int=%b pend=%b, want 0 1000", bus.interrupt, bus.pending);
    end
    tick();
    pop_exp();
    checks++;
    if (bus.interrupt !== 1'b1 || bus.int_addr !== exp_addr || bus.int_id !== exp_id) begin
      errors++;
      $display("FAIL prio_second: int=%b addr=%h id=%0d, want 1 %h %0d",
               bus.interrupt, bus.int_addr, bus.int_id, exp_addr, exp_id);
    end
    service_current();
    tick();
  endtask

  task automatic test_no_preempt();
    push_exp(2'd3);
    set_done(4'b1000);
    tick();
    set_done(4'b0000);
    tick();
    pop_exp();
    checks++;
    if (bus.interrupt !== 1'b1 || bus.int_addr !== exp_addr) begin
      errors++;
      $display("FAIL nopre_req: int=%b addr=%h, want 1 %h", bus.interrupt, bus.int_addr, exp_addr);
    end
    set_done(4'b0001);
    tick();
    set_done(4'b0000);
    tick();
    checks++;
    if (bus.int_addr !== 32'h130 || bus.int_id !== 2'd3 || bus.pending !== 4'b1001 ||
        bus.interrupt !== 1'b1) begin
      errors++;
      $display("FAIL nopre_hold: addr=%h id=%0d pend=%b int=%b, want 00000130 3 1001 1",
               bus.int_addr, bus.int_id, bus.pending, bus.interrupt);
    end
    push_exp(2'd0);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    checks++;
    if (bus.pending !== 4'b0001 || bus.interrupt !== 1'b0) begin
      errors++;
      $display("FAIL nopre_service: pend=%b int=%b, want 0001 0", bus.pending, bus.interrupt);
    end
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tick();
    pop_exp();
    checks++;
    if (bus.interrupt !== 1'b1 || bus.int_addr !== exp_addr || bus.int_id !== exp_id) begin
      errors++;
      $display("FAIL nopre_next: int=%b addr=%h id=%0d, want 1 %h %0d",
               bus.interrupt, bus.int_addr, bus.int_id, exp_addr, exp_id);
    end
    service_current();
    tick();
  endtask

  task automatic test_mask();
    bit seen;
    int n;
    bus.int_mask = 4'b1110;
    set_done(4'b0001);
    tick();
    set_done(4'b0000);
    tick();
    tick();
    checks++;
    if (bus.pending !== 4'b0001 || bus.interrupt !== 1'b0) begin
      errors++;
      $display("FAIL mask_hold: pend=%b int=%b, want 0001 0", bus.pending, bus.interrupt);
    end
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    checks++;
    if (bus.pending !== 4'b0001 || bus.interrupt !== 1'b0 || bus.in_service !== 1'b0) begin
      errors++;
      $display("FAIL mask_ignore: pend=%b int=%b svc=%b, want 0001 0 0",
               bus.pending, bus.interrupt, bus.in_service);
    end
    push_exp(2'd0);
    bus.int_mask = 4'hF;
    wait_interrupt(8, seen, n);
    pop_exp();
    checks++;
    if (!seen || n > 2 || bus.int_addr !== exp_addr || bus.int_id !== exp_id) begin
      errors++;
      $display("FAIL mask_release: seen=%0d edges=%0d addr=%h id=%0d, want 1 <=2 %h %0d",
               seen, n, bus.int_addr, bus.int_id, exp_addr, exp_id);
    end
    service_current();
    tick();
  endtask

  task automatic test_same_cycle();
    push_exp(2'd1);
    set_done(4'b0010);
    tick();
    set_done(4'b0000);
    tick();
    pop_exp();
    checks++;
    if (bus.interrupt !== 1'b1 || bus.int_addr !== exp_addr) begin
      errors++;
      $display("FAIL same_req: int=%b addr=%h, want 1 %h", bus.interrupt, bus.int_addr, exp_addr);
    end
    push_exp(2'd1);
    bus.int_ack = 1'b1;
    set_done(4'b0010);
    tick();
    bus.int_ack = 1'b0;
    set_done(4'b0000);
    checks++;
    if (bus.pending !== 4'b0010 || bus.interrupt !== 1'b0 || bus.in_service !== 1'b1) begin
      errors++;
      $display("FAIL same_repend: pend=%b int=%b svc=%b, want 0010 0 1",
               bus.pending, bus.interrupt, bus.in_service);
    end
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    checks++;
    if (bus.interrupt !== 1'b0) begin
      errors++;
      $display("FAIL same_gap: int=%b, want 0", bus.interrupt);
    end
    tick();
    pop_exp();
    checks++;
    if (bus.interrupt !== 1'b1 || bus.int_addr !== exp_addr || bus.int_id !== exp_id) begin
      errors++;
      $display("FAIL same_rereq: int=%b addr=%h id=%0d, want 1 %h %0d",
               bus.interrupt, bus.int_addr, bus.int_id, exp_addr, exp_id);
    end
    service_current();
    tick();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset_n      = 1'b0;
    set_done(4'b0000);
    bus.int_mask = 4'hF;
    bus.int_ack  = 1'b0;
    bus.eoi      = 1'b0;
    #2;
    test_reset();
    test_single();
    test_priority();
    test_no_preempt();
    test_mask();
    test_same_cycle();
    checks++;
    if (exp_id_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_id_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
